// File: rtl/rps_game_fsm.sv
// rps_game_fsm: rock-paper-scissors round controller feeding the VGA display stage
// Ports:
//   clk                                 system clock
//   rst                                 asynchronous active-low reset
//   btn_start                           one-cycle pulse, starts a match from IDLE
//   btn_rock, btn_paper, btn_scissors   one-cycle pulses, player hand select
//   state                               0 IDLE, 1 SELECT, 2 REVEAL, 3 RESULT
//   player_hand, com_hand               0 none, 1 rock, 2 paper, 3 scissors
//   result                              0 none, 1 player win, 2 computer win, 3 draw
//   player_score, com_score             saturating match scores
//   match_over                          high once a score reaches WIN_TARGET
// Build option RPS_LFSR_EN selects an 8-bit LFSR computer hand instead of the
// deterministic 1->2->3 cyclic counter.
module rps_game_fsm #(
    parameter logic [31:0] REVEAL_CYCLES  = 32'd100_000_000,
    parameter logic [31:0] RESULT_CYCLES  = 32'd200_000_000,
    parameter logic [31:0] SELECT_TIMEOUT = 32'd500_000_000,
    parameter logic [3:0]  WIN_TARGET     = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_rock,
    input  logic       btn_paper,
    input  logic       btn_scissors,
    output logic [1:0] state,
    output logic [1:0] player_hand,
    output logic [1:0] com_hand,
    output logic [1:0] result,
    output logic [3:0] player_score,
    output logic [3:0] com_score,
    output logic       match_over
);
    typedef enum logic [1:0] {IDLE = 2'd0, SELECT = 2'd1, REVEAL = 2'd2, RESULT = 2'd3} state_t;
    state_t      st;
    logic [31:0] timer;
    logic [1:0]  gen_hand;
    logic        press;
    logic [1:0]  pick;
    logic [2:0]  diff;
    logic [1:0]  judged;
    logic        p_inc;
    logic        c_inc;
    logic [3:0]  p_new;
    logic [3:0]  c_new;
    logic        sel_done;
    logic        rev_done;
    logic        res_done;
`ifdef RPS_LFSR_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'h01;
        else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign gen_hand = 2'(lfsr % 8'd3) + 2'd1;
`else
    logic [1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 2'd1;
        else cnt <= (cnt == 2'd3) ? 2'd1 : cnt + 2'd1;
    end
    assign gen_hand = cnt;
`endif
    always_comb begin
        press    = btn_rock | btn_paper | btn_scissors;
        pick     = btn_rock ? 2'd1 : btn_paper ? 2'd2 : btn_scissors ? 2'd3 : 2'd0;
        diff     = ({1'b0, player_hand} + 3'd3 - {1'b0, com_hand}) % 3'd3;
        judged   = (player_hand == 2'd0) ? 2'd2 : (diff == 3'd0) ? 2'd3 : (diff == 3'd1) ? 2'd1 : 2'd2;
        p_inc    = (judged == 2'd1) && (player_score != 4'hF);
        c_inc    = (judged == 2'd2) && (com_score != 4'hF);
        p_new    = player_score + {3'd0, p_inc};
        c_new    = com_score + {3'd0, c_inc};
        sel_done = timer == SELECT_TIMEOUT - 32'd1;
        rev_done = timer == REVEAL_CYCLES - 32'd1;
        res_done = timer == RESULT_CYCLES - 32'd1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= IDLE;
            timer        <= 32'd0;
            player_hand  <= 2'd0;
            com_hand     <= 2'd0;
            result       <= 2'd0;
            player_score <= 4'd0;
            com_score    <= 4'd0;
            match_over   <= 1'b0;
        end else begin
            timer <= timer + 32'd1;
            case (st)
                IDLE: if (btn_start) begin
                    st           <= SELECT;
                    timer        <= 32'd0;
                    player_hand  <= 2'd0;
                    com_hand     <= 2'd0;
                    result       <= 2'd0;
                    player_score <= 4'd0;
                    com_score    <= 4'd0;
                    match_over   <= 1'b0;
                end
                SELECT: if (press || sel_done) begin
                    st          <= REVEAL;
                    timer       <= 32'd0;
                    player_hand <= pick;
                    com_hand    <= gen_hand;
                end
                REVEAL: if (rev_done) begin
                    st           <= RESULT;
                    timer        <= 32'd0;
                    result       <= judged;
                    player_score <= p_new;
                    com_score    <= c_new;
                    match_over   <= (p_inc && p_new == WIN_TARGET) || (c_inc && c_new == WIN_TARGET);
                end
                RESULT: if (res_done) begin
                    st    <= match_over ? IDLE : SELECT;
                    timer <= 32'd0;
                    if (!match_over) begin
                        player_hand <= 2'd0;
                        com_hand    <= 2'd0;
                        result      <= 2'd0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
    assign state = st;
endmodule

// File: tb/tb_rps_game_fsm.sv
// tb_rps_game_fsm: directed table plus randomized checking of rps_game_fsm against a round-level model
module tb_rps_game_fsm;
    localparam int         REV = 4;
    localparam int         RES = 4;
    localparam int         SEL = 20;
    localparam logic [3:0] WIN = 4'd2;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_rock = 1'b0;
    logic       btn_paper = 1'b0;
    logic       btn_scissors = 1'b0;
    logic [1:0] state;
    logic [1:0] player_hand;
    logic [1:0] com_hand;
    logic [1:0] result;
    logic [3:0] player_score;
    logic [3:0] com_score;
    logic       match_over;
    rps_game_fsm #(
        .REVEAL_CYCLES(32'd4),
        .RESULT_CYCLES(32'd4),
        .SELECT_TIMEOUT(32'd20),
        .WIN_TARGET(4'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_start(btn_start),
        .btn_rock(btn_rock),
        .btn_paper(btn_paper),
        .btn_scissors(btn_scissors),
        .state(state),
        .player_hand(player_hand),
        .com_hand(com_hand),
        .result(result),
        .player_score(player_score),
        .com_score(com_score),
        .match_over(match_over)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int         m_phase;
    int         m_left;
    int         m_k;
    logic [1:0] m_ph;
    logic [1:0] m_ch;
    logic [1:0] m_res;
    logic [3:0] m_ps;
    logic [3:0] m_cs;
    logic       m_mo;
    typedef struct {
        logic        st;
        logic        r;
        logic        p;
        logic        s;
        int          n;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[23];
    function automatic vec_t mk(input logic st, input logic r, input logic p, input logic s, input int n,
                                input logic [1:0] es, input logic [1:0] eph, input logic [1:0] ech,
                                input logic [1:0] eres, input logic [3:0] eps, input logic [3:0] ecs,
                                input logic emo);
        vec_t v;
        v.st  = st;
        v.r   = r;
        v.p   = p;
        v.s   = s;
        v.n   = n;
        v.exp = {es, eph, ech, eres, eps, ecs, emo};
        return v;
    endfunction
    function automatic logic [16:0] dut_vec();
        return {state, player_hand, com_hand, result, player_score, com_score, match_over};
    endfunction
    function automatic logic [16:0] mdl_vec();
        return {2'(m_phase), m_ph, m_ch, m_res, m_ps, m_cs, m_mo};
    endfunction
    function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
        if (p == 2'd0) return 2'd2;
        if (p == c) return 2'd3;
        return ((p == 2'd1 && c == 2'd3) || (p == 2'd2 && c == 2'd1) || (p == 2'd3 && c == 2'd2)) ? 2'd1 : 2'd2;
    endfunction
    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask
    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_k     = 0;
        m_ph    = 2'd0;
        m_ch    = 2'd0;
        m_res   = 2'd0;
        m_ps    = 4'd0;
        m_cs    = 4'd0;
        m_mo    = 1'b0;
    endtask
    task automatic model_step();
        logic [1:0] g;
        if (!rst) begin
            model_reset();
        end else begin
            g = 2'((m_k % 3) + 1);
            m_k++;
            case (m_phase)
                0: if (btn_start) begin
                    m_phase = 1;
                    m_left  = SEL;
                    m_ph = 2'd0; m_ch = 2'd0; m_res = 2'd0; m_ps = 4'd0; m_cs = 4'd0; m_mo = 1'b0;
                end
                1: begin
                    m_left--;
                    if (btn_rock || btn_paper || btn_scissors || m_left == 0) begin
                        m_ph    = btn_rock ? 2'd1 : btn_paper ? 2'd2 : btn_scissors ? 2'd3 : 2'd0;
                        m_ch    = g;
                        m_phase = 2;
                        m_left  = REV;
                    end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_res = judge(m_ph, m_ch);
                        if (m_res == 2'd1 && m_ps != 4'hF) m_ps++;
                        if (m_res == 2'd2 && m_cs != 4'hF) m_cs++;
                        m_mo    = (m_res == 2'd1 && m_ps == WIN) || (m_res == 2'd2 && m_cs == WIN);
                        m_phase = 3;
                        m_left  = RES;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_mo) m_phase = 0;
                        else begin
                            m_phase = 1;
                            m_left  = SEL;
                            m_ph = 2'd0; m_ch = 2'd0; m_res = 2'd0;
                        end
                    end
                end
            endcase
        end
    endtask
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", dut_vec(), mdl_vec());
    endtask
    task automatic drive(input logic st, input logic r, input logic p, input logic s);
        btn_start    = st;
        btn_rock     = r;
        btn_paper    = p;
        btn_scissors = s;
    endtask
    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0,  2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[2]  = mk(0, 0, 0, 0, 0,  2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[3]  = mk(0, 0, 1, 0, 0,  2'd2, 2'd2, 2'd1, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[4]  = mk(0, 0, 0, 0, 2,  2'd2, 2'd2, 2'd1, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[5]  = mk(0, 0, 0, 0, 0,  2'd3, 2'd2, 2'd1, 2'd1, 4'd1, 4'd0, 1'b0);
        tbl[6]  = mk(0, 0, 0, 0, 3,  2'd1, 2'd0, 2'd0, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[7]  = mk(0, 1, 0, 0, 0,  2'd2, 2'd1, 2'd1, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[8]  = mk(0, 0, 0, 0, 3,  2'd3, 2'd1, 2'd1, 2'd3, 4'd1, 4'd0, 1'b0);
        tbl[9]  = mk(0, 0, 0, 0, 3,  2'd1, 2'd0, 2'd0, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[10] = mk(1, 1, 0, 1, 0,  2'd2, 2'd1, 2'd1, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[11] = mk(0, 0, 0, 0, 3,  2'd3, 2'd1, 2'd1, 2'd3, 4'd1, 4'd0, 1'b0);
        tbl[12] = mk(0, 0, 0, 0, 3,  2'd1, 2'd0, 2'd0, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[13] = mk(0, 0, 0, 0, 18, 2'd1, 2'd0, 2'd0, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[14] = mk(0, 0, 0, 0, 0,  2'd2, 2'd0, 2'd2, 2'd0, 4'd1, 4'd0, 1'b0);
        tbl[15] = mk(0, 0, 0, 0, 3,  2'd3, 2'd0, 2'd2, 2'd2, 4'd1, 4'd1, 1'b0);
        tbl[16] = mk(0, 0, 0, 0, 3,  2'd1, 2'd0, 2'd0, 2'd0, 4'd1, 4'd1, 1'b0);
        tbl[17] = mk(0, 0, 0, 1, 0,  2'd2, 2'd3, 2'd2, 2'd0, 4'd1, 4'd1, 1'b0);
        tbl[18] = mk(0, 0, 0, 0, 3,  2'd3, 2'd3, 2'd2, 2'd1, 4'd2, 4'd1, 1'b1);
        tbl[19] = mk(0, 0, 0, 0, 3,  2'd0, 2'd3, 2'd2, 2'd1, 4'd2, 4'd1, 1'b1);
        tbl[20] = mk(0, 1, 0, 0, 1,  2'd0, 2'd3, 2'd2, 2'd1, 4'd2, 4'd1, 1'b1);
        tbl[21] = mk(1, 0, 0, 0, 0,  2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b0);
        tbl[22] = mk(0, 1, 0, 0, 0,  2'd2, 2'd1, 2'd2, 2'd0, 4'd0, 4'd0, 1'b0);
        model_reset();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 17'd0);
        rst = 1'b1;
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].st, tbl[i].r, tbl[i].p, tbl[i].s);
            step();
            drive(0, 0, 0, 0);
            for (int j = 0; j < tbl[i].n; j++) step();
            chk($sformatf("row%0d", i), dut_vec(), tbl[i].exp);
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_in_reveal", dut_vec(), 17'd0);
        model_reset();
        repeat (2) step();
        rst = 1'b1;
        drive(1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        repeat (19) step();
        chk("select_before_timeout", {13'd0, state, player_hand}, {13'd0, 2'd1, 2'd0});
        drive(0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        chk("press_on_timeout", {13'd0, state, player_hand}, {13'd0, 2'd2, 2'd2});
        for (int i = 0; i < 4000; i++) begin
            if (rst && $urandom_range(0, 499) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(0, 2) == 0) rst = 1'b1;
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            step();
        end
        drive(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
